// File: rtl/fpnew_opgroup_result_fifo.sv
// fpnew_opgroup_result_fifo
//
// Output buffer placed directly after an operation group. It accepts the
// group's result stream (result, status, extension bit, tag) into a
// Depth-entry FIFO. A stalled downstream consumer therefore does not stall
// the group's pipeline straight away. It also keeps a sticky OR of the
// status flags of every entry it hands downstream.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   flush_i               synchronous flush, drops all buffered entries
//   result_i, status_i,
//   extension_bit_i,
//   tag_i                 incoming entry fields
//   in_valid_i/in_ready_o upstream handshake
//   result_o, status_o,
//   extension_bit_o,
//   tag_o                 head entry fields
//   out_valid_o/out_ready_i downstream handshake
//   fflags_o              sticky OR of popped status flags
//   fflags_clr_i          clears the sticky flags
//   count_o               number of buffered entries
//   busy_o                at least one entry buffered
module fpnew_opgroup_result_fifo #(
  parameter int unsigned Width    = 32,
  parameter int unsigned Depth    = 4,
  parameter int unsigned TagWidth = 1,
  localparam int unsigned CntW    = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic [Width-1:0]    result_i,
  input  logic [4:0]          status_i,
  input  logic                extension_bit_i,
  input  logic [TagWidth-1:0] tag_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  output logic [Width-1:0]    result_o,
  output logic [4:0]          status_o,
  output logic                extension_bit_o,
  output logic [TagWidth-1:0] tag_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [4:0]          fflags_o,
  input  logic                fflags_clr_i,
  output logic [CntW-1:0]     count_o,
  output logic                busy_o
);

  // Depth = 1 still needs a one-bit pointer so the declarations stay legal.
  localparam int unsigned    PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  typedef struct packed {
    logic [Width-1:0]    result;
    logic [4:0]          status;
    logic                ext_bit;
    logic [TagWidth-1:0] tag;
  } entry_t;

  entry_t          mem_q [Depth];
  logic [PtrW-1:0] wptr_q;
  logic [PtrW-1:0] rptr_q;
  logic [CntW-1:0] cnt_q;
  logic [4:0]      fflags_q;
  logic            push;
  logic            pop;
  entry_t          head;

  // Ready is based only on occupancy and flush, so the input side never
  // waits combinationally on the downstream ready. A pop frees the slot
  // for the next cycle, not the current one.
  assign in_ready_o  = (cnt_q != FullCnt) && !flush_i;
  assign out_valid_o = (cnt_q != '0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  assign head            = mem_q[rptr_q];
  assign result_o        = head.result;
  assign status_o        = head.status;
  assign extension_bit_o = head.ext_bit;
  assign tag_o           = head.tag;
  assign fflags_o        = fflags_q;
  assign count_o         = cnt_q;
  assign busy_o          = out_valid_o;

  // Storage is not reset. Entries are only visible through cnt, so stale
  // contents never leak out.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= {result_i, status_i, extension_bit_i, tag_i};
    end
  end

  // Pointers and occupancy. The pointers wrap explicitly at Depth-1 so
  // that a Depth that is not a power of two works. A simultaneous push and
  // pop leaves the count unchanged.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        wptr_q <= (wptr_q == LastPtr) ? '0 : wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= (rptr_q == LastPtr) ? '0 : rptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Sticky exception flags. The clear acts on the old value only, so a pop
  // in the same cycle as a clear still contributes its flags. An entry
  // popped while flushing is discarded and does not contribute.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fflags_q <= '0;
    end else begin
      fflags_q <= (fflags_clr_i ? 5'b0 : fflags_q)
                | ((pop && !flush_i) ? head.status : 5'b0);
    end
  end

endmodule

// File: tb/tb_fpnew_opgroup_result_fifo.sv
// Testbench for fpnew_opgroup_result_fifo. A negedge monitor keeps a
// scoreboard queue of expected entries and a model of the sticky flags.
// Directed sequences drive the scenarios of interest and add targeted
// checks at the points that matter.
module tb_fpnew_opgroup_result_fifo;

  localparam int Width    = 32;
  localparam int Depth    = 4;
  localparam int TagWidth = 1;
  localparam int CntW     = $clog2(Depth + 1);

  typedef struct {
    logic [Width-1:0]    result;
    logic [4:0]          status;
    logic                extBit;
    logic [TagWidth-1:0] tag;
  } sbEntry_t;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                flush_i;
  logic [Width-1:0]    result_i;
  logic [4:0]          status_i;
  logic                extension_bit_i;
  logic [TagWidth-1:0] tag_i;
  logic                in_valid_i;
  logic                in_ready_o;
  logic [Width-1:0]    result_o;
  logic [4:0]          status_o;
  logic                extension_bit_o;
  logic [TagWidth-1:0] tag_o;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [4:0]          fflags_o;
  logic                fflags_clr_i;
  logic [CntW-1:0]     count_o;
  logic                busy_o;

  sbEntry_t sbQueue[$];
  logic [4:0] modelFlags = '0;
  int checkCount = 0;
  int failCount  = 0;

  fpnew_opgroup_result_fifo #(
    .Width(Width), .Depth(Depth), .TagWidth(TagWidth)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .result_i(result_i), .status_i(status_i),
    .extension_bit_i(extension_bit_i), .tag_i(tag_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .result_o(result_o), .status_o(status_o),
    .extension_bit_o(extension_bit_o), .tag_o(tag_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i),
    .count_o(count_o), .busy_o(busy_o)
  );

  // 10-unit clock period.
  always #5 clk_i = ~clk_i;

  // Counts every comparison and reports any mismatch.
  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
    end
  endtask

  // Drives one set of inputs. They are applied just after a rising edge
  // and held until the next one.
  task automatic applyStimulus(input logic valid, input logic [Width-1:0] data,
                               input logic [4:0] status, input logic ext,
                               input logic [TagWidth-1:0] tag, input logic outReady,
                               input logic flush, input logic clr);
    in_valid_i      = valid;
    result_i        = data;
    status_i        = status;
    extension_bit_i = ext;
    tag_i           = tag;
    out_ready_i     = outReady;
    flush_i         = flush;
    fflags_clr_i    = clr;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard monitor. It samples at the falling edge, compares the DUT
  // against the model and then advances the model to predict the next
  // rising edge.
  always @(negedge clk_i) begin
    if (rst_i) begin
      checkOutput("rst_out_valid", out_valid_o, 1'b0);
      checkOutput("rst_count", count_o, '0);
      checkOutput("rst_fflags", fflags_o, '0);
      sbQueue.delete();
      modelFlags = '0;
    end else begin
      automatic bit mReady = (sbQueue.size() != Depth) && !flush_i;
      automatic bit mValid = (sbQueue.size() != 0);
      automatic bit doPush = in_valid_i && mReady;
      automatic bit doPop  = mValid && out_ready_i;
      automatic logic [4:0] nextFlags = fflags_clr_i ? 5'b0 : modelFlags;
      checkOutput("count", count_o, sbQueue.size());
      checkOutput("out_valid", out_valid_o, mValid);
      checkOutput("busy", busy_o, mValid);
      checkOutput("in_ready", in_ready_o, mReady);
      checkOutput("fflags", fflags_o, modelFlags);
      if (mValid) begin
        checkOutput("head_result", result_o, sbQueue[0].result);
        checkOutput("head_status", status_o, sbQueue[0].status);
        checkOutput("head_ext", extension_bit_o, sbQueue[0].extBit);
        checkOutput("head_tag", tag_o, sbQueue[0].tag);
      end
      if (doPop) begin
        automatic sbEntry_t head = sbQueue.pop_front();
        if (!flush_i) nextFlags = nextFlags | head.status;
      end
      if (flush_i) begin
        sbQueue.delete();
      end else if (doPush) begin
        sbQueue.push_back('{result_i, status_i, extension_bit_i, tag_i});
      end
      modelFlags = nextFlags;
    end
  end

  // Watchdog so the run always ends, even if a step is stuck.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i = 1'b1;
    applyStimulus(0, '0, '0, 0, '0, 0, 0, 0);
    step();
    step();
    rst_i = 1'b0;
    checkOutput("reset_out_valid", out_valid_o, 1'b0);
    checkOutput("reset_busy", busy_o, 1'b0);
    checkOutput("reset_in_ready", in_ready_o, 1'b1);
    checkOutput("reset_count", count_o, 0);
    checkOutput("reset_fflags", fflags_o, 0);

    // Single entry: visible one cycle after the push, then popped.
    applyStimulus(1, 32'h3F80_0000, 5'b00001, 0, 1'b1, 0, 0, 0);
    step();
    applyStimulus(0, '0, '0, 0, '0, 1, 0, 0);
    checkOutput("single_valid", out_valid_o, 1'b1);
    checkOutput("single_result", result_o, 32'h3F80_0000);
    checkOutput("single_status", status_o, 5'b00001);
    checkOutput("single_tag", tag_o, 1'b1);
    step();
    applyStimulus(0, '0, '0, 0, '0, 0, 0, 0);
    checkOutput("single_fflags", fflags_o, 5'b00001);
    checkOutput("single_count", count_o, 0);

    // Fill with the output stalled, then drain. 0x5 waits for the first pop.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1, Width'(i), 5'(i), i[0], TagWidth'(i), 0, 0, 0);
      step();
    end
    checkOutput("full_count", count_o, 4);
    checkOutput("full_in_ready", in_ready_o, 1'b0);
    applyStimulus(1, 32'h5, 5'b00000, 1, 1'b1, 1, 0, 0);
    #1;
    checkOutput("full_ready_with_out_ready", in_ready_o, 1'b0);
    step();
    checkOutput("after_pop_in_ready", in_ready_o, 1'b1);
    checkOutput("after_pop_head", result_o, 32'h2);
    step();
    applyStimulus(0, '0, '0, 0, '0, 1, 0, 0);
    checkOutput("refill_count", count_o, 3);
    for (int i = 0; i < 4; i++) step();
    checkOutput("drained_count", count_o, 0);

    // Wrap-around: continuous push and pop keeps exactly one entry buffered.
    for (int i = 0; i <= 10; i++) begin
      applyStimulus(1, Width'(32'h100 + i), 5'b00000, 0, TagWidth'(i), 1, 0, 0);
      step();
      checkOutput("stream_count", count_o, 1);
    end
    applyStimulus(0, '0, '0, 0, '0, 1, 0, 0);
    step();

    // Flush: set fflags to NV, buffer 3 entries, flush while a pop and a
    // push are offered. The popped entry's flags must be dropped.
    applyStimulus(0, '0, '0, 0, '0, 0, 0, 1);
    step();
    applyStimulus(1, 32'hAA, 5'b10000, 0, 1'b0, 0, 0, 0);
    step();
    applyStimulus(0, '0, '0, 0, '0, 1, 0, 0);
    step();
    checkOutput("flush_pre_fflags", fflags_o, 5'b10000);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, Width'(32'hB0 + i), 5'b00010, 1, 1'b1, 0, 0, 0);
      step();
    end
    checkOutput("flush_pre_count", count_o, 3);
    applyStimulus(1, 32'hCC, 5'b00001, 0, 1'b0, 1, 1, 0);
    #1;
    checkOutput("flush_in_ready", in_ready_o, 1'b0);
    step();
    applyStimulus(0, '0, '0, 0, '0, 0, 0, 0);
    checkOutput("flush_count", count_o, 0);
    checkOutput("flush_out_valid", out_valid_o, 1'b0);
    checkOutput("flush_fflags", fflags_o, 5'b10000);

    // Clear vs pop: the popped flags survive a same-cycle clear.
    applyStimulus(0, '0, '0, 0, '0, 0, 0, 1);
    step();
    applyStimulus(1, 32'hD0, 5'b00100, 0, 1'b0, 0, 0, 0);
    step();
    applyStimulus(1, 32'hD1, 5'b01000, 0, 1'b1, 1, 0, 0);
    step();
    checkOutput("clr_pre_fflags", fflags_o, 5'b00100);
    applyStimulus(0, '0, '0, 0, '0, 1, 0, 1);
    step();
    applyStimulus(0, '0, '0, 0, '0, 0, 0, 0);
    checkOutput("clr_pop_fflags", fflags_o, 5'b01000);

    // Asynchronous reset mid-cycle with two entries buffered.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, Width'(32'hE0 + i), 5'b00011, 0, 1'b0, 0, 0, 0);
      step();
    end
    checkOutput("areset_pre_count", count_o, 2);
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput("areset_out_valid", out_valid_o, 1'b0);
    checkOutput("areset_count", count_o, 0);
    checkOutput("areset_fflags", fflags_o, 0);
    applyStimulus(0, '0, '0, 0, '0, 0, 0, 0);
    step();
    rst_i = 1'b0;
    step();

    // Normal traffic after reset.
    applyStimulus(1, 32'hF0, 5'b00001, 1, 1'b1, 0, 0, 0);
    step();
    applyStimulus(0, '0, '0, 0, '0, 1, 0, 0);
    checkOutput("post_reset_result", result_o, 32'hF0);
    step();
    step();
    checkOutput("post_reset_count", count_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
